// File: rtl/entrada_pio_pkg.sv
// Shared constants for the debounced switch/key PIO.
//
// Contents:
//   REG_*    Avalon-MM register word offsets
//   EDGE_*   values for the EDGE_MODE parameter
//   cnt_width()  bit width needed to hold counter values 0..n-1
package entrada_pio_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_IRQMASK = 2'd1;
  localparam logic [1:0] REG_EDGECAP = 2'd2;
  localparam logic [1:0] REG_TS      = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Never returns 0 so that a counter vector is always at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/entrada_pio_deb_debounce_cell.sv
// Single-channel input conditioner: 2-flop synchroniser, stability counter and
// the accepted ("stable") level.
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   din     raw asynchronous input
//   stable  debounced level; follows din only after DEBOUNCE_CYCLES
//           consecutive synchronised samples that disagree with it
module debounce_cell
  import entrada_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync0_q;
  logic            sync1_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync1_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync0_q  <= din;
      sync1_q  <= sync0_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/entrada_pio_deb.sv
// Debounced switch/key PIO with edge capture and maskable interrupt, exposed
// as an Avalon-MM slave.
//
// Ports:
//   clk_clk        system clock
//   reset_reset    synchronous active-high reset
//   pins_in        raw asynchronous switch/key inputs [WIDTH-1:0]
//   avs_address    register word address (0 DATA, 1 IRQMASK, 2 EDGECAPTURE,
//                  3 TIMESTAMP)
//   avs_read       read strobe
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   read data, valid the cycle after avs_read, held otherwise
//   irq            registered level interrupt, |(edgecapture & irqmask)
//
// Build option: define ENTRADA_PIO_TS_EN to add a free-running 32-bit cycle
// counter whose value is latched into TIMESTAMP whenever an edgecapture bit is
// newly set. Without it, address 3 reads 0.
module entrada_pio_deb
  import entrada_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 19,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  // Arming window: sync latency plus one full debounce period, so levels
  // present at power-up settle into stable without being reported as edges.
  localparam int unsigned ArmCycles = DEBOUNCE_CYCLES + 2;
  localparam int unsigned ArmW      = cnt_width(ArmCycles + 1);
  localparam logic [ArmW-1:0] ArmLast = ArmW'(ArmCycles);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_last_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;

  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             irq_q;
  logic             irq_d;

  logic [ArmW-1:0]  arm_cnt_q;
  logic [ArmW-1:0]  arm_cnt_d;
  logic             armed_q;
  logic             armed_d;

  logic [31:0]      rd_word;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic [31:0]      ts_word;

  logic             unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // ---------------------------------------------------------------------------
  // Per-channel synchronise + debounce
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .din   (pins_in[i]),
      .stable(stable[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Arming
  // ---------------------------------------------------------------------------
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      arm_cnt_d = arm_cnt_q + 1'b1;
      if (arm_cnt_q == ArmLast) begin
        armed_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection and capture
  // ---------------------------------------------------------------------------
  always_comb begin
    rise = stable & ~stable_last_q;
    fall = ~stable & stable_last_q;
    if (EDGE_MODE == EDGE_FALL) begin
      edges = fall;
    end else if (EDGE_MODE == EDGE_ANY) begin
      edges = rise | fall;
    end else begin
      edges = rise;
    end
  end

  assign cap_set = armed_q ? edges : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    cap_clr   = '0;
    if (avs_write && (avs_address == REG_IRQMASK)) begin
      irqmask_d = avs_writedata[WIDTH-1:0];
    end
    if (avs_write && (avs_address == REG_EDGECAP)) begin
      cap_clr = avs_writedata[WIDTH-1:0];
    end
    // A new edge overrides a same-cycle write-1-to-clear.
    edgecap_d = (edgecap_q & ~cap_clr) | cap_set;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // ---------------------------------------------------------------------------
  // Optional timestamp
  // ---------------------------------------------------------------------------
`ifdef ENTRADA_PIO_TS_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;
  logic        ts_hit;

  assign ts_hit = |(cap_set & ~edgecap_q);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (ts_hit) begin
        ts_q <= ts_cnt_q;
      end
    end
  end

  assign ts_word = ts_q;
`else
  assign ts_word = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: reads sample pre-write state, so a same-cycle write is invisible
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    unique case (avs_address)
      REG_DATA:    rd_word[WIDTH-1:0] = stable;
      REG_IRQMASK: rd_word[WIDTH-1:0] = irqmask_q;
      REG_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
      REG_TS:      rd_word            = ts_word;
      default:     rd_word            = '0;
    endcase
    readdata_d = avs_read ? rd_word : readdata_q;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable_last_q <= '0;
      irqmask_q     <= '0;
      edgecap_q     <= '0;
      irq_q         <= 1'b0;
      arm_cnt_q     <= '0;
      armed_q       <= 1'b0;
      readdata_q    <= '0;
    end else begin
      stable_last_q <= stable;
      irqmask_q     <= irqmask_d;
      edgecap_q     <= edgecap_d;
      irq_q         <= irq_d;
      arm_cnt_q     <= arm_cnt_d;
      armed_q       <= armed_d;
      readdata_q    <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule
